// File: rtl/key_expand_ctrl.sv
// AES-128 key-schedule engine: expands one round key per cycle through four
// shared S-boxes and serves any stored round key with one-cycle read latency.

module sbox (
  input  logic [7:0] input_byte,
  output logic [7:0] output_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign output_byte = SBOX[input_byte];
endmodule

module key_expand_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   round_number,
  output logic [127:0] round_key
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic         key_loaded;
  logic [127:0] work;
  logic [127:0] key_file [0:NR];
  logic         accept;
  logic [31:0]  w3, temp, w4, w5, w6, w7;
  logic [7:0]   sb0, sb1, sb2, sb3;
  logic [127:0] next_key;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign accept = key_valid && key_ready;

  // RotWord is folded into the S-box wiring: byte lanes feed the boxes pre-rotated.
  assign w3 = work[31:0];
  sbox u_sbox0 (.input_byte(w3[23:16]), .output_byte(sb0));
  sbox u_sbox1 (.input_byte(w3[15:8]),  .output_byte(sb1));
  sbox u_sbox2 (.input_byte(w3[7:0]),   .output_byte(sb2));
  sbox u_sbox3 (.input_byte(w3[31:24]), .output_byte(sb3));

  assign temp     = {sb0, sb1, sb2, sb3} ^ {rcon, 24'h0};
  assign w4       = work[127:96] ^ temp;
  assign w5       = work[95:64] ^ w4;
  assign w6       = work[63:32] ^ w5;
  assign w7       = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rcon       <= 8'h01;
      key_loaded <= 1'b0;
      round_key  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= 4'd1;
        rcon       <= 8'h01;
        key_loaded <= 1'b1;
      end else if (state == EXPAND) begin
        cnt  <= cnt + 4'd1;
        rcon <= xtime(rcon);
      end
      // Read sees the pre-edge file contents, so a write on this edge is not yet visible.
      round_key <= (key_loaded && round_number <= LAST) ? key_file[round_number] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      key_file[0] <= cipher_key;
      work        <= cipher_key;
    end else if (state == EXPAND) begin
      key_file[cnt] <= next_key;
      work          <= next_key;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (cnt == LAST) state_nxt = DONE;
      DONE:    if (accept) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready  = (state != EXPAND);
    busy       = (state == EXPAND);
    keys_valid = (state == DONE);
  end
endmodule

// File: tb/tb_key_expand_ctrl.sv
// Bench for key_expand_ctrl: word-level FIPS-197 key-schedule model with a
// GF(2^8) S-box, cycle compare of all outputs, plus literal round-key checks.

module tb_key_expand_ctrl;
  typedef logic [0:10][127:0] sched_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] cipher_key = '0;
  logic [3:0]   round_number = 4'd0;
  logic         key_ready, busy, keys_valid;
  logic [127:0] round_key;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  key_expand_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .cipher_key(cipher_key), .busy(busy), .keys_valid(keys_valid),
    .round_number(round_number), .round_key(round_key)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // ---------------- behavioural model ----------------
  sched_t       m_sched;
  logic [127:0] m_file [0:10];
  int           m_age;
  logic         m_busy, m_kv, m_loaded, m_rk_chk;
  logic [127:0] m_rk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_kv <= 1'b0; m_loaded <= 1'b0;
      m_age <= 0; m_rk <= '0; m_rk_chk <= 1'b1;
    end else begin
      m_rk_chk <= !m_loaded || round_number > 4'd10 || m_kv;
      m_rk     <= (!m_loaded || round_number > 4'd10) ? '0 : m_file[round_number];
      if (key_valid && !m_busy) begin
        m_sched   <= expand(cipher_key);
        m_file[0] <= cipher_key;
        m_age     <= 0;
        m_busy    <= 1'b1;
        m_kv      <= 1'b0;
        m_loaded  <= 1'b1;
      end else if (m_busy) begin
        m_file[m_age+1] <= m_sched[m_age+1];
        m_age <= m_age + 1;
        if (m_age == 9) begin
          m_busy <= 1'b0;
          m_kv   <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    chk("cyc_key_ready", 128'(key_ready), 128'(!m_busy));
    chk("cyc_busy", 128'(busy), 128'(m_busy));
    chk("cyc_keys_valid", 128'(keys_valid), 128'(m_kv));
    if (m_rk_chk) chk("cyc_round_key", round_key, m_rk);
  end

  // ---------------- stimulus ----------------
  task automatic load(input logic [127:0] k);
    @(negedge clk);
    chk("ready_before_accept", 128'(key_ready), 128'd1);
    key_valid  = 1'b1;
    cipher_key = k;
    @(negedge clk);
    key_valid  = 1'b0;
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_accept", 128'(busy), 128'd1);
    chk("kv_after_accept", 128'(keys_valid), 128'd0);
  endtask

  task automatic wait_done(input bit check_latency, input bit noisy);
    int n = 0;
    while (!keys_valid && n < 40) begin
      if (noisy) begin
        round_number = 4'($urandom_range(0, 15));
        key_valid    = $urandom_range(0, 1) == 1;
        cipher_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      n++;
    end
    key_valid = 1'b0;
    chk("keys_valid_timeout", 128'(keys_valid), 128'd1);
    if (check_latency) chk("latency", 128'(n), 128'd10);
  endtask

  task automatic rd(input logic [3:0] rn, input logic [127:0] exp, input string name);
    @(negedge clk);
    round_number = rn;
    @(negedge clk);
    chk(name, round_key, exp);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_round_key", round_key, '0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);

    load(FIPS_KEY);
    wait_done(1'b1, 1'b0);
    rd(4'd1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "fips_r1");
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "fips_r10");
    rd(4'd0, FIPS_KEY, "fips_r0");

    load(128'h00112233445566778899aabbccddeeff);
    wait_done(1'b1, 1'b0);
    rd(4'd1, 128'hc0393478846c520f0cf5f8b4c028164b, "k2_r1");
    rd(4'd10, 128'h36d024461d84b8375fc0f9c04cbab6bb, "k2_r10");
    rd(4'd0, 128'h00112233445566778899aabbccddeeff, "k2_r0");

    load('0);
    key_valid  = 1'b1;
    cipher_key = FIPS_KEY;
    @(negedge clk);
    chk("ready_in_expand", 128'(key_ready), 128'd0);
    @(negedge clk);
    key_valid = 1'b0;
    wait_done(1'b0, 1'b0);
    rd(4'd1, 128'h62636363626363636263636362636363, "zero_r1");
    rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_r10");
    rd(4'd11, '0, "oob_r11");
    rd(4'd15, '0, "oob_r15");

    load(FIPS_KEY);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_keys_valid", 128'(keys_valid), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_key_ready", 128'(key_ready), 128'd1);
    chk("abort_round_key", round_key, '0);
    @(negedge clk);
    rst_n = 1'b1;
    load(FIPS_KEY);
    wait_done(1'b1, 1'b0);
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "reload_r10");

    for (int k = 0; k < 6; k++) begin
      load({$urandom, $urandom, $urandom, $urandom});
      wait_done(1'b1, 1'b1);
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        round_number = 4'($urandom_range(0, 15));
        key_valid    = $urandom_range(0, 7) == 0;
        cipher_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      key_valid = 1'b0;
      wait_done(1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
